// File: rtl/module3_mini.sv
// module3_mini: two-product coin vending transaction core.
// Accepts 5/10-unit coins one per clock, accumulates credit against the
// selected product's price, vends with change and tracks stock per product.
// Optional feature: define REFUND_EN so that an idle cycle (no coin) returns
// any accumulated credit on change and ends the transaction.
module module3_mini (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] prod_name,
   input  logic [1:0] in,
   output logic [1:0] out,
   output logic [4:0] change,
   output logic [1:0] prod_count1,
   output logic [1:0] prod_count2
);

   localparam logic [4:0] PRICE1     = 5'd15;
   localparam logic [4:0] PRICE2     = 5'd20;
   localparam logic [1:0] INIT_STOCK = 2'd3;

   logic [4:0] credit_q, credit_d;
   logic [1:0] out_q, out_d;
   logic [4:0] change_q, change_d;
   logic [1:0] count1_q, count1_d;
   logic [1:0] count2_q, count2_d;

   logic [4:0] coin_val;
   logic [4:0] price;
   logic [4:0] sum;
   logic       coin_present;
   logic       prod_valid;
   logic       sold_out;

   // Decode coin value, selected price/stock and the running sum.
   // Credit stays <= 15 between coins, so credit+coin fits in 5 bits.
   always_comb begin
      coin_val     = 5'd0;
      coin_present = 1'b0;
      case (in)
         2'd1: begin coin_val = 5'd5;  coin_present = 1'b1; end
         2'd2: begin coin_val = 5'd10; coin_present = 1'b1; end
         default: begin coin_val = 5'd0; coin_present = 1'b0; end
      endcase
      prod_valid = (prod_name == 2'd1) || (prod_name == 2'd2);
      price      = (prod_name == 2'd2) ? PRICE2 : PRICE1;
      sold_out   = (prod_name == 2'd2) ? (count2_q == 2'd0) : (count1_q == 2'd0);
      sum        = credit_q + coin_val;
   end

   // Next-state rules, first match wins: idle, bad select, sold out,
   // vend, accumulate. out/change default to 0 so they pulse one cycle.
   always_comb begin
      credit_d = credit_q;
      out_d    = 2'd0;
      change_d = 5'd0;
      count1_d = count1_q;
      count2_d = count2_q;
      if (!coin_present) begin
`ifdef REFUND_EN
         if (credit_q != 5'd0) begin
            change_d = credit_q;
            credit_d = 5'd0;
         end
`endif
      end else if (!prod_valid || sold_out) begin
         // Coin is bounced straight back; accumulated credit is kept.
         change_d = coin_val;
      end else if (sum >= price) begin
         out_d    = prod_name;
         change_d = sum - price;
         credit_d = 5'd0;
         if (prod_name == 2'd1) count1_d = count1_q - 2'd1;
         else                   count2_d = count2_q - 2'd1;
      end else begin
         credit_d = sum;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_q <= 5'd0;
         out_q    <= 2'd0;
         change_q <= 5'd0;
         count1_q <= INIT_STOCK;
         count2_q <= INIT_STOCK;
      end else begin
         credit_q <= credit_d;
         out_q    <= out_d;
         change_q <= change_d;
         count1_q <= count1_d;
         count2_q <= count2_d;
      end
   end

   assign out         = out_q;
   assign change      = change_q;
   assign prod_count1 = count1_q;
   assign prod_count2 = count2_q;

endmodule

// File: tb/tb_module3_mini.sv
// Directed testbench for module3_mini with hand-computed expectations.
module tb_module3_mini;

   logic       clk;
   logic       rst;
   logic [1:0] prod_name;
   logic [1:0] in;
   logic [1:0] out;
   logic [4:0] change;
   logic [1:0] prod_count1;
   logic [1:0] prod_count2;

   int total;
   int bad;

   module3_mini dut (
      .clk         (clk),
      .rst         (rst),
      .prod_name   (prod_name),
      .in          (in),
      .out         (out),
      .change      (change),
      .prod_count1 (prod_count1),
      .prod_count2 (prod_count2)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] e_out, input logic [4:0] e_chg,
                            input logic [1:0] e_c1, input logic [1:0] e_c2);
      check({tag, ".out"}, {30'd0, out}, {30'd0, e_out});
      check({tag, ".change"}, {27'd0, change}, {27'd0, e_chg});
      check({tag, ".count1"}, {30'd0, prod_count1}, {30'd0, e_c1});
      check({tag, ".count2"}, {30'd0, prod_count2}, {30'd0, e_c2});
   endtask

   // Present one coin for exactly one edge, then sample 1 time unit later.
   task automatic coin(input logic [1:0] p, input logic [1:0] c);
      prod_name = p;
      in        = c;
      @(posedge clk);
      #1;
      in = 2'd0;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      in        = 2'd0;
      prod_name = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      in    = 2'd0;
      prod_name = 2'd0;

      apply_reset();
      check_all("reset", 2'd0, 5'd0, 2'd3, 2'd3);

      // Product 1 from 10+10
      coin(2'd1, 2'd2); check_all("p1_c1", 2'd0, 5'd0, 2'd3, 2'd3);
      coin(2'd1, 2'd2); check_all("p1_vend", 2'd1, 5'd5, 2'd2, 2'd3);
      coin(2'd1, 2'd0); check_all("pulse_clear", 2'd0, 5'd0, 2'd2, 2'd3);

      // Product 2 from 5+10+10 then 10+10
      coin(2'd2, 2'd1); check_all("p2_c1", 2'd0, 5'd0, 2'd2, 2'd3);
      coin(2'd2, 2'd2); check_all("p2_c2", 2'd0, 5'd0, 2'd2, 2'd3);
      coin(2'd2, 2'd2); check_all("p2_vend_a", 2'd2, 5'd5, 2'd2, 2'd2);
      coin(2'd2, 2'd2); check_all("p2_c4", 2'd0, 5'd0, 2'd2, 2'd2);
      coin(2'd2, 2'd2); check_all("p2_vend_b", 2'd2, 5'd0, 2'd2, 2'd1);

      // Drain product 1 to zero, then sold-out rejection
      coin(2'd1, 2'd1);
      coin(2'd1, 2'd2); check_all("p1_vend_b", 2'd1, 5'd0, 2'd1, 2'd1);
      coin(2'd1, 2'd1);
      coin(2'd1, 2'd2); check_all("p1_vend_c", 2'd1, 5'd0, 2'd0, 2'd1);
      coin(2'd1, 2'd2); check_all("p1_soldout", 2'd0, 5'd10, 2'd0, 2'd1);

      // Rejections keep the accumulated credit (10 on product 2)
      coin(2'd2, 2'd2); check_all("keep_c1", 2'd0, 5'd0, 2'd0, 2'd1);
      coin(2'd1, 2'd2); check_all("keep_soldout", 2'd0, 5'd10, 2'd0, 2'd1);
      coin(2'd0, 2'd1); check_all("keep_bad0", 2'd0, 5'd5, 2'd0, 2'd1);
      coin(2'd3, 2'd2); check_all("keep_bad3", 2'd0, 5'd10, 2'd0, 2'd1);
      coin(2'd2, 2'd2); check_all("keep_vend", 2'd2, 5'd0, 2'd0, 2'd0);
      coin(2'd2, 2'd1); check_all("p2_soldout", 2'd0, 5'd5, 2'd0, 2'd0);

      // Idle cycle with credit pending
      apply_reset();
      coin(2'd1, 2'd1); check_all("idle_c1", 2'd0, 5'd0, 2'd3, 2'd3);
      coin(2'd1, 2'd0);
`ifdef REFUND_EN
      check_all("idle_refund", 2'd0, 5'd5, 2'd3, 2'd3);
      coin(2'd1, 2'd2); check_all("idle_after", 2'd0, 5'd0, 2'd3, 2'd3);
`else
      check_all("idle_hold", 2'd0, 5'd0, 2'd3, 2'd3);
      coin(2'd1, 2'd2); check_all("idle_after", 2'd1, 5'd0, 2'd2, 2'd3);
`endif

      // in=3 is treated as no coin
      apply_reset();
      coin(2'd1, 2'd2);
      coin(2'd1, 2'd3);
`ifdef REFUND_EN
      check_all("in3_idle", 2'd0, 5'd10, 2'd3, 2'd3);
      coin(2'd1, 2'd1); check_all("in3_after", 2'd0, 5'd0, 2'd3, 2'd3);
`else
      check_all("in3_idle", 2'd0, 5'd0, 2'd3, 2'd3);
      coin(2'd1, 2'd1); check_all("in3_after", 2'd1, 5'd0, 2'd2, 2'd3);
`endif

      // Mid-transaction product switch keeps credit
      apply_reset();
      coin(2'd1, 2'd2); check_all("sw_c1", 2'd0, 5'd0, 2'd3, 2'd3);
      coin(2'd2, 2'd2); check_all("sw_vend", 2'd2, 5'd0, 2'd3, 2'd2);

      // Asynchronous reset clears a visible vend pulse immediately
      coin(2'd1, 2'd2);
      coin(2'd1, 2'd2); check_all("ar_vend", 2'd1, 5'd5, 2'd2, 2'd2);
      #2 rst = 1'b1;
      #1 check_all("ar_async", 2'd0, 5'd0, 2'd3, 2'd3);
      #1 rst = 1'b0;

      // Reset mid-transaction drops credit
      @(posedge clk); #1;
      coin(2'd1, 2'd2);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      coin(2'd1, 2'd2); check_all("ar_nostale", 2'd0, 5'd0, 2'd3, 2'd3);
      coin(2'd1, 2'd2); check_all("ar_vend2", 2'd1, 5'd5, 2'd2, 2'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
